// File: rtl/pairwise_seq_pkg.sv
// Shared types and helpers for the pairwise-gate sequencer.
// Optional feature macro: PAIRWISE_SEQ_OVERLAP_EN (see pairwise_gates_seq_ctrl).
package pairwise_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Number of CHUNK-wide slices needed to cover the NBITS-1 output bits
    function automatic int nchunks(input int nbits, input int chunk);
        return (nbits - 1 + chunk - 1) / chunk;
    endfunction

    // Chunk counter width, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pairwise_gates_chunk.sv
// One CHUNK-wide slice of the pairwise AND/OR/XNOR datapath.
// Purely combinational; CHUNK+1 input bits give CHUNK result bits.
module pairwise_gates_chunk
    import pairwise_seq_pkg::*;
#(
    parameter int CHUNK = 20
) (
    input  logic [CHUNK:0]   in_,
    output logic [CHUNK-1:0] out_and,
    output logic [CHUNK-1:0] out_or,
    output logic [CHUNK-1:0] out_xnor
);

    assign out_and  = in_[CHUNK-1:0] & in_[CHUNK:1];
    assign out_or   = in_[CHUNK-1:0] | in_[CHUNK:1];
    assign out_xnor = ~(in_[CHUNK-1:0] ^ in_[CHUNK:1]);

endmodule

// File: rtl/pairwise_gates_seq_ctrl.sv
// Sequencer sweeping a wide vector through one CHUNK-wide pairwise-gate slice.
// Macro PAIRWISE_SEQ_OVERLAP_EN lets DONE hand off and accept in one cycle.
module pairwise_gates_seq_ctrl
    import pairwise_seq_pkg::*;
#(
    parameter int NBITS = 100,
    parameter int CHUNK = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-2:0] out_and,
    output logic [NBITS-2:0] out_or,
    output logic [NBITS-2:0] out_xnor,
    output logic             busy
);

    localparam int NCHUNKS = nchunks(NBITS, CHUNK);
    localparam int IDXW    = idx_width(NCHUNKS);
    localparam int PADW    = NCHUNKS * CHUNK + 1;
    localparam int ONBITS  = NBITS - 1;

    state_t state;
    state_t next_state;

    logic [IDXW-1:0]   chunk_idx;
    logic [NBITS-1:0]  in_reg;
    logic [PADW-1:0]   in_pad;
    logic [CHUNK:0]    slice;
    logic [CHUNK-1:0]  sl_and;
    logic [CHUNK-1:0]  sl_or;
    logic [CHUNK-1:0]  sl_xnor;
    logic [ONBITS-1:0] and_d;
    logic [ONBITS-1:0] or_d;
    logic [ONBITS-1:0] xnor_d;
    logic              accept;
    logic              last_chunk;

    // Zero padding lets the partial last chunk read past the top bit
    assign in_pad     = PADW'(in_reg);
    assign last_chunk = (chunk_idx == IDXW'(NCHUNKS - 1));
    assign out_val    = (state == DONE);
    assign busy       = (state == CALC);

    // Select the CHUNK+1 input bits feeding the current chunk
    always_comb begin
        slice = '0;
        for (int k = 0; k < NCHUNKS; k++) begin
            if (chunk_idx == IDXW'(k)) begin
                slice = in_pad[k*CHUNK +: CHUNK+1];
            end
        end
    end

    pairwise_gates_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .in_      (slice),
        .out_and  (sl_and),
        .out_or   (sl_or),
        .out_xnor (sl_xnor)
    );

    // Merge the slice result into the in-range bits of the active chunk
    always_comb begin
        and_d  = out_and;
        or_d   = out_or;
        xnor_d = out_xnor;
        for (int i = 0; i < ONBITS; i++) begin
            if (state == CALC && chunk_idx == IDXW'(i / CHUNK)) begin
                and_d[i]  = sl_and[i % CHUNK];
                or_d[i]   = sl_or[i % CHUNK];
                xnor_d[i] = sl_xnor[i % CHUNK];
            end
        end
    end

    // Handshake and next-state decode
    always_comb begin
        next_state = state;
        in_rdy     = 1'b0;
        unique case (state)
            IDLE: in_rdy = ~reset;
            CALC: in_rdy = 1'b0;
`ifdef PAIRWISE_SEQ_OVERLAP_EN
            DONE: in_rdy = out_rdy & ~reset;
`else
            DONE: in_rdy = 1'b0;
`endif
            default: in_rdy = 1'b0;
        endcase
        accept = in_val & in_rdy;
        unique case (state)
            IDLE: if (accept) next_state = CALC;
            CALC: if (last_chunk) next_state = DONE;
            DONE: if (out_rdy) next_state = accept ? CALC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, counter, captured input and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            chunk_idx <= '0;
            in_reg    <= '0;
            out_and   <= '0;
            out_or    <= '0;
            out_xnor  <= '0;
        end else begin
            state    <= next_state;
            out_and  <= and_d;
            out_or   <= or_d;
            out_xnor <= xnor_d;
            if (accept) begin
                in_reg    <= in_;
                chunk_idx <= '0;
            end else if (state == CALC) begin
                chunk_idx <= chunk_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pairwise_gates_seq_ctrl.sv
// Self-checking bench for pairwise_gates_seq_ctrl.
// Honours PAIRWISE_SEQ_OVERLAP_EN for the expected back-to-back spacing.
module tb_pairwise_gates_seq_ctrl;

    localparam int NBITS = 100;
    localparam int CHUNK = 20;
    localparam int NCH   = 5;
    localparam int OW    = NBITS - 1;
`ifdef PAIRWISE_SEQ_OVERLAP_EN
    localparam int SPACING = NCH + 1;
`else
    localparam int SPACING = NCH + 2;
`endif

    typedef struct packed {
        logic [OW-1:0] a;
        logic [OW-1:0] o;
        logic [OW-1:0] x;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_val = 1'b0;
    logic             in_rdy;
    logic [NBITS-1:0] in_ = '0;
    logic             out_val;
    logic             out_rdy = 1'b0;
    logic [OW-1:0]    out_and;
    logic [OW-1:0]    out_or;
    logic [OW-1:0]    out_xnor;
    logic             busy;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pairwise_gates_seq_ctrl #(
        .NBITS(NBITS),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_      (in_),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_and  (out_and),
        .out_or   (out_or),
        .out_xnor (out_xnor),
        .busy     (busy)
    );

    function automatic exp_t golden(input logic [NBITS-1:0] v);
        exp_t e;
        for (int i = 0; i < OW; i++) begin
            e.a[i] = v[i] & v[i+1];
            e.o[i] = v[i] | v[i+1];
            e.x[i] = ~(v[i] ^ v[i+1]);
        end
        return e;
    endfunction

    function automatic logic [NBITS-1:0] rand_vec();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[NBITS-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (in_rdy !== 1'b0 || out_val !== 1'b0 || busy !== 1'b0 ||
            out_and !== '0 || out_or !== '0 || out_xnor !== '0) begin
            bad++;
            $display("FAIL reset_hold: in_rdy=%b out_val=%b busy=%b and=%h or=%h xnor=%h, required 0",
                     in_rdy, out_val, busy, out_and, out_or, out_xnor);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_rdy=%b out_val=%b busy=%b, required 1 0 0",
                     in_rdy, out_val, busy);
        end
        tick();
    endtask

    task automatic run_one(input string name, input logic [NBITS-1:0] v, input exp_t e);
        exp_t got;
        exp_t want;
        bit   seen;
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_     = v;
        seen    = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (in_rdy) seen = 1'b1;
            tick();
        end
        in_val = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_accept: in_rdy stayed 0, required 1", name);
            return;
        end
        sb.push_back(e);
        seen = 1'b0;
        got  = '0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (out_val) begin
                seen = 1'b1;
                got  = {out_and, out_or, out_xnor};
            end else begin
                tick();
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: out_val stayed 0, required 1", name);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL %s: and=%h or=%h xnor=%h, required and=%h or=%h xnor=%h",
                         name, got.a, got.o, got.x, want.a, want.o, want.x);
            end
        end
        tick();
    endtask

    task automatic test_patterns();
        exp_t e;
        e.a = '0;
        e.o = '0;
        e.x = 99'h7_ffff_ffff_ffff_ffff_ffff_ffff;
        run_one("t1_zero", 100'h0, e);
        e.a = 99'h7_ffff_ffff_ffff_ffff_ffff_ffff;
        e.o = 99'h7_ffff_ffff_ffff_ffff_ffff_ffff;
        e.x = 99'h7_ffff_ffff_ffff_ffff_ffff_ffff;
        run_one("t2_ones", 100'hf_ffff_ffff_ffff_ffff_ffff_ffff, e);
        e.a = '0;
        e.o = 99'h7_ffff_ffff_ffff_ffff_ffff_ffff;
        e.x = '0;
        run_one("t3_alt", 100'h5_5555_5555_5555_5555_5555_5555, e);
        run_one("t3_top_bit", 100'h8_0000_0000_0000_0000_0000_0001,
                golden(100'h8_0000_0000_0000_0000_0000_0001));
    endtask

    task automatic test_latency_backpressure();
        logic [NBITS-1:0] v;
        exp_t             held;
        exp_t             want;
        v       = 100'h3_1234_5678_9abc_def0_1357_9bdf;
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_     = v;
        @(negedge clk);
        total++;
        if (in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL t4_idle_rdy: in_rdy=%b, required 1", in_rdy);
        end
        tick();
        sb.push_back(golden(v));
        in_ = ~v;
        for (int c = 1; c <= NCH; c++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1 || out_val !== 1'b0 || in_rdy !== 1'b0) begin
                bad++;
                $display("FAIL t4_calc_c%0d: busy=%b out_val=%b in_rdy=%b, required 1 0 0",
                         c, busy, out_val, in_rdy);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (out_val !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL t4_done_c6: out_val=%b busy=%b, required 1 0", out_val, busy);
        end
        held = {out_and, out_or, out_xnor};
        want = sb.pop_front();
        total++;
        if (held !== want) begin
            bad++;
            $display("FAIL t4_result: and=%h or=%h xnor=%h, required and=%h or=%h xnor=%h",
                     held.a, held.o, held.x, want.a, want.o, want.x);
        end
        for (int h = 0; h < 10; h++) begin
            tick();
            @(negedge clk);
            total++;
            if (out_val !== 1'b1 || in_rdy !== 1'b0 ||
                {out_and, out_or, out_xnor} !== held) begin
                bad++;
                $display("FAIL t4_hold_%0d: out_val=%b in_rdy=%b and=%h, required 1 0 and=%h",
                         h, out_val, in_rdy, out_and, held.a);
            end
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL t4_release: out_val=%b in_rdy=%b, required 0 1", out_val, in_rdy);
        end
        tick();
    endtask

    task automatic test_reset_mid_calc();
        logic [NBITS-1:0] v;
        v       = 100'h8_dead_beef_dead_beef_dead_beef;
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_     = '1;
        @(negedge clk);
        tick();
        sb.push_back(golden('1));
        in_val = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (in_rdy !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL t5_pre_reset: in_rdy=%b busy=%b, required 0 1", in_rdy, busy);
        end
        tick();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        total++;
        if (out_val !== 1'b0 || busy !== 1'b0 || in_rdy !== 1'b1 ||
            out_and !== '0 || out_or !== '0 || out_xnor !== '0) begin
            bad++;
            $display("FAIL t5_after_reset: out_val=%b busy=%b in_rdy=%b and=%h or=%h xnor=%h, required 0 0 1 and zeros",
                     out_val, busy, in_rdy, out_and, out_or, out_xnor);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge clk);
            total++;
            if (out_val !== 1'b0) begin
                bad++;
                $display("FAIL t5_no_spurious_%0d: out_val=%b, required 0", c, out_val);
            end
        end
        tick();
        run_one("t5_deadbeef", v, golden(v));
    endtask

    task automatic test_back_to_back();
        logic [NBITS-1:0] vec;
        exp_t             got;
        exp_t             want;
        int               n_in;
        int               n_out;
        int               last;
        bit               acc;
        n_in    = 0;
        n_out   = 0;
        last    = -1;
        vec     = rand_vec();
        in_     = vec;
        in_val  = 1'b1;
        out_rdy = 1'b1;
        for (int cyc = 0; cyc < 400 && n_out < 20; cyc++) begin
            @(negedge clk);
            acc = 1'b0;
            if (out_val) begin
                got = {out_and, out_or, out_xnor};
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL t6_unexpected_out: out_val=1 with no pending input");
                end else begin
                    want = sb.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL t6_result_%0d: and=%h or=%h xnor=%h, required and=%h or=%h xnor=%h",
                                 n_out, got.a, got.o, got.x, want.a, want.o, want.x);
                    end
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last != SPACING) begin
                        bad++;
                        $display("FAIL t6_spacing_%0d: %0d cycles, required %0d",
                                 n_out, cyc - last, SPACING);
                    end
                end
                last = cyc;
                n_out++;
            end
            if (in_val && in_rdy) begin
                sb.push_back(golden(vec));
                n_in++;
                acc = 1'b1;
            end
            tick();
            if (acc) begin
                vec = rand_vec();
                in_ = vec;
            end
            if (n_in >= 20) in_val = 1'b0;
        end
        in_val = 1'b0;
        total++;
        if (n_out < 20) begin
            bad++;
            $display("FAIL t6_timeout: %0d outputs, required 20", n_out);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_latency_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
